// File: rtl/mcpu_if.sv
// Shared memory/IO bus between the mcpu core and the memory/IO controller.
interface mcpu_if;
    logic        MIO_ready;
    logic [31:0] Data_in;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        mem_w;
    logic        CPU_MIO;

    modport master (
        input  MIO_ready, Data_in,
        output Addr_out, Data_out, mem_w, CPU_MIO
    );

    modport slave (
        output MIO_ready, Data_in,
        input  Addr_out, Data_out, mem_w, CPU_MIO
    );
endinterface

// File: rtl/mcpu.sv
// Multi-cycle MIPS-subset core: one shared bus for fetch and load/store,
// datapath registers sequenced by a 15-state FSM.
module mcpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        INT,
    mcpu_if.master      bus,
    output logic [31:0] PC_out,
    output logic [31:0] inst_out,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        S_IF   = 5'd0,  S_ID   = 5'd1,  S_EXM  = 5'd2,
        S_MRD  = 5'd3,  S_WBL  = 5'd4,  S_MWR  = 5'd5,
        S_EXR  = 5'd6,  S_WBR  = 5'd7,  S_EXB  = 5'd8,
        S_EXJ  = 5'd9,  S_EXI  = 5'd10, S_WBI  = 5'd11,
        S_JAL  = 5'd12, S_JR   = 5'd13, S_ERR  = 5'd14
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic        int_unused;
    assign int_unused = INT;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext, zext;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign target = ir_q[25:0];
    assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zext   = {16'd0, ir_q[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    logic is_mem, is_r, is_jr, is_br, is_i;
    assign is_mem = (op == OP_LW) || (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_jr  = is_r && (funct == 6'h08);
    assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
    assign is_i   = (op == OP_ADDI) || (op == OP_SLTI) ||
                    (op == OP_ANDI) || (op == OP_ORI)  ||
                    (op == OP_XORI) || (op == OP_LUI);

    logic r_ok;
    always_comb begin
        r_ok = 1'b0;
        unique case (funct)
            6'h00, 6'h02, 6'h20, 6'h22, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2A: r_ok = 1'b1;
            default: r_ok = 1'b0;
        endcase
    end

    logic [31:0] r_res, i_res;
    always_comb begin
        r_res = 32'd0;
        unique case (funct)
            6'h00:   r_res = b_q << shamt;
            6'h02:   r_res = b_q >> shamt;
            6'h20:   r_res = a_q + b_q;
            6'h22:   r_res = a_q - b_q;
            6'h24:   r_res = a_q & b_q;
            6'h25:   r_res = a_q | b_q;
            6'h26:   r_res = a_q ^ b_q;
            6'h27:   r_res = ~(a_q | b_q);
            6'h2A:   r_res = {31'd0, $signed(a_q) < $signed(b_q)};
            default: r_res = 32'd0;
        endcase
    end

    always_comb begin
        i_res = 32'd0;
        unique case (op)
            OP_ADDI: i_res = a_q + sext;
            OP_SLTI: i_res = {31'd0, $signed(a_q) < $signed(sext)};
            OP_ANDI: i_res = a_q & zext;
            OP_ORI:  i_res = a_q | zext;
            OP_XORI: i_res = a_q ^ zext;
            OP_LUI:  i_res = {ir_q[15:0], 16'd0};
            default: i_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rf_we   = 1'b0;
        rf_wa   = 5'd0;
        rf_wd   = 32'd0;
        unique case (state_q)
            S_IF: begin
                if (bus.MIO_ready) begin
                    ir_d    = bus.Data_in;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + (sext << 2);
                unique case (1'b1)
                    is_mem:          state_d = S_EXM;
                    is_jr:           state_d = S_JR;
                    is_r && r_ok:    state_d = S_EXR;
                    is_br:           state_d = S_EXB;
                    op == OP_J:      state_d = S_EXJ;
                    op == OP_JAL:    state_d = S_JAL;
                    is_i:            state_d = S_EXI;
                    default:         state_d = S_ERR;
                endcase
            end
            S_EXM: begin
                alu_d   = a_q + sext;
                state_d = (op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                if (bus.MIO_ready) begin
                    mdr_d   = bus.Data_in;
                    state_d = S_WBL;
                end
            end
            S_WBL: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = mdr_q;
                state_d = S_IF;
            end
            S_MWR: begin
                if (bus.MIO_ready) state_d = S_IF;
            end
            S_EXR: begin
                alu_d   = r_res;
                state_d = S_WBR;
            end
            S_WBR: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                rf_wd   = alu_q;
                state_d = S_IF;
            end
            S_EXI: begin
                alu_d   = i_res;
                state_d = S_WBI;
            end
            S_WBI: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = alu_q;
                state_d = S_IF;
            end
            S_EXB: begin
                // bne inverts the equality test
                if ((a_q == b_q) ^ (op == OP_BNE)) pc_d = alu_q;
                state_d = S_IF;
            end
            S_EXJ: begin
                pc_d    = {pc_q[31:28], target, 2'b00};
                state_d = S_IF;
            end
            S_JAL: begin
                pc_d    = {pc_q[31:28], target, 2'b00};
                rf_we   = 1'b1;
                rf_wa   = 5'd31;
                rf_wd   = pc_q;
                state_d = S_IF;
            end
            S_JR: begin
                pc_d    = a_q;
                state_d = S_IF;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            if (rf_we && (rf_wa != 5'd0)) rf_q[rf_wa] <= rf_wd;
        end
    end

    assign bus.Addr_out = (state_q == S_IF) ? pc_q : alu_q;
    assign bus.Data_out = b_q;
    assign bus.mem_w    = (state_q == S_MWR);
    assign bus.CPU_MIO  = (state_q == S_IF) || (state_q == S_MRD) ||
                          (state_q == S_MWR);
    assign PC_out       = pc_q;
    assign inst_out     = ir_q;
    assign state        = state_q;

endmodule

// File: tb/tb_mcpu.sv
// Directed program for mcpu; stores are checked against a scoreboard
// of expected {address, data} pairs.
module tb_mcpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        INT;
    logic [31:0] PC_out;
    logic [31:0] inst_out;
    logic [4:0]  state;

    mcpu_if bus ();

    mcpu dut (
        .clk      (clk),
        .reset    (reset),
        .INT      (INT),
        .bus      (bus.master),
        .PC_out   (PC_out),
        .inst_out (inst_out),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Store monitor: a write completes on an edge with mem_w and ready
    always @(posedge clk) begin
        if (reset === 1'b1 && bus.mem_w === 1'b1 &&
            bus.MIO_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("st_addr", bus.Addr_out, e[63:32]);
                chk("st_data", bus.Data_out, e[31:0]);
            end
        end
    end

    // Runs one instruction from IF back to IF, bounded at 20 cycles
    task automatic exec(input logic [31:0] ins, input logic [31:0] rdata,
                        input logic [31:0] raddr, input int stalls,
                        input int exp_cyc, input logic [31:0] exp_pc,
                        input string tag);
        int cyc = 0;
        int st  = stalls;
        bus.Data_in   = ins;
        bus.MIO_ready = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            bus.MIO_ready = 1'b1;
            if (state == 5'd3) begin
                chk({tag, "_raddr"}, bus.Addr_out, raddr);
                chk({tag, "_rmio"}, {31'd0, bus.CPU_MIO}, 32'd1);
                bus.Data_in = rdata;
            end
            if (state == 5'd5) begin
                chk({tag, "_memw"}, {31'd0, bus.mem_w}, 32'd1);
                chk({tag, "_wmio"}, {31'd0, bus.CPU_MIO}, 32'd1);
            end
            if ((state == 5'd3 || state == 5'd5) && st > 0) begin
                bus.MIO_ready = 1'b0;
                st--;
            end
        end while (state != 5'd0 && cyc < 20);
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_pc"}, PC_out, exp_pc);
    endtask

    initial begin
        logic [4:0] seq [4];
        seq = '{5'd1, 5'd6, 5'd7, 5'd0};
        reset         = 1'b0;
        INT           = 1'b0;
        bus.MIO_ready = 1'b1;
        bus.Data_in   = 32'h0000_0820;

        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", PC_out, 32'd0);
        chk("rst_ir", inst_out, 32'd0);
        chk("rst_addr", bus.Addr_out, 32'd0);
        chk("rst_memw", {31'd0, bus.mem_w}, 32'd0);
        chk("rst_mio", {31'd0, bus.CPU_MIO}, 32'd1);
        reset = 1'b1;

        foreach (seq[i]) begin
            @(negedge clk);
            chk("add_seq", 32'(state), 32'(seq[i]));
        end
        chk("add_pc", PC_out, 32'd4);
        chk("add_ir", inst_out, 32'h0000_0820);

        exec(32'h8C22_0000, 32'd1, 32'd0, 0, 5, 32'd8, "lw");
        sb.push_back({32'd0, 32'd1});
        exec(32'hAC22_0000, 32'd0, 32'd0, 1, 5, 32'd12, "sw_r2");
        exec(32'h1041_0002, 32'd0, 32'd0, 0, 3, 32'd16, "bne_path");
        exec(32'h1020_0002, 32'd0, 32'd0, 0, 3, 32'd28, "beq_taken");
        exec(32'h2003_FFFB, 32'd0, 32'd0, 0, 4, 32'd32, "addi");
        exec(32'h3404_00F0, 32'd0, 32'd0, 0, 4, 32'd36, "ori");
        exec(32'h0083_2822, 32'd0, 32'd0, 0, 4, 32'd40, "sub");
        exec(32'h0064_302A, 32'd0, 32'd0, 0, 4, 32'd44, "slt");
        exec(32'h0004_3900, 32'd0, 32'd0, 0, 4, 32'd48, "sll");
        exec(32'h3C08_1234, 32'd0, 32'd0, 0, 4, 32'd52, "lui");

        sb.push_back({32'd4, 32'h0000_00F5});
        exec(32'hAC05_0004, 32'd0, 32'd0, 0, 4, 32'd56, "sw_r5");
        sb.push_back({32'd8, 32'h0000_0001});
        exec(32'hAC06_0008, 32'd0, 32'd0, 0, 4, 32'd60, "sw_r6");
        sb.push_back({32'd12, 32'h0000_0F00});
        exec(32'hAC07_000C, 32'd0, 32'd0, 0, 4, 32'd64, "sw_r7");
        sb.push_back({32'd16, 32'h1234_0000});
        exec(32'hAC08_0010, 32'd0, 32'd0, 0, 4, 32'd68, "sw_r8");
        sb.push_back({32'd20, 32'hFFFF_FFFB});
        exec(32'hAC03_0014, 32'd0, 32'd0, 0, 4, 32'd72, "sw_r3");

        exec(32'h0C00_0010, 32'd0, 32'd0, 0, 3, 32'h40, "jal");
        sb.push_back({32'd24, 32'd76});
        exec(32'hAC1F_0018, 32'd0, 32'd0, 0, 4, 32'h44, "sw_r31");
        exec(32'h03E0_0008, 32'd0, 32'd0, 0, 3, 32'd76, "jr");

        bus.MIO_ready = 1'b0;
        bus.Data_in   = 32'h0800_0008;
        repeat (2) begin
            @(negedge clk);
            chk("ifstall_state", 32'(state), 32'd0);
            chk("ifstall_ir", inst_out, 32'h03E0_0008);
        end
        exec(32'h0800_0008, 32'd0, 32'd0, 0, 3, 32'h20, "j");

        bus.Data_in = 32'hFC00_0000;
        @(negedge clk);
        chk("undef_id", 32'(state), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("err_state", 32'(state), 32'd14);
        end

        reset = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_pc", PC_out, 32'd0);
        chk("arst_memw", {31'd0, bus.mem_w}, 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        bus.Data_in = 32'h0000_0820;
        @(negedge clk);
        chk("refetch_state", 32'(state), 32'd1);
        chk("refetch_pc", PC_out, 32'd4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
